// File: rtl/keypad_code_entry.sv
// Keypad code entry: gathers digit presses into a code, presents it to the lock with a one-cycle
// strobe, then tracks the lock's grant/lockout response with timeout and grant hold.
module keypad_code_entry #(
    parameter int unsigned DIGITS       = 4,
    parameter int unsigned DIGIT_W      = 4,
    parameter int unsigned RESP_TIMEOUT = 8,
    parameter int unsigned GRANT_HOLD   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        key_valid,
    input  logic [DIGIT_W-1:0]          key_digit,
    input  logic                        key_clear,
    input  logic                        key_enter,
    input  logic                        lock_ok,
    input  logic                        lock_locked,
    output logic [DIGITS*DIGIT_W-1:0]   code,
    output logic                        code_valid,
    output logic                        granted,
    output logic                        denied,
    output logic                        entry_error,
    output logic                        locked_out,
    output logic [$clog2(DIGITS+1)-1:0] digit_count,
    output logic [1:0]                  fail_count,
    output logic                        busy
);

    localparam int unsigned CODE_W  = DIGITS * DIGIT_W;
    localparam int unsigned CNT_W   = $clog2(DIGITS + 1);
    localparam int unsigned TMR_MAX = (RESP_TIMEOUT > GRANT_HOLD) ? RESP_TIMEOUT : GRANT_HOLD;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    typedef enum logic [2:0] {
        StCollect,
        StSend,
        StWaitResp,
        StGranted,
        StLockout
    } state_e;

    state_e             state_q, state_d;
    logic [CODE_W-1:0]  code_q, code_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         fail_q, fail_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               code_valid_q, granted_q, denied_q, denied_d;
    logic               entry_error_q, entry_error_d, locked_out_q, busy_q;

    always_comb begin
        state_d       = state_q;
        code_d        = code_q;
        cnt_d         = cnt_q;
        fail_d        = fail_q;
        timer_d       = timer_q;
        denied_d      = 1'b0;
        entry_error_d = 1'b0;
        case (state_q)
            StCollect: begin
                if (key_clear) begin
                    code_d = '0;
                    cnt_d  = '0;
                end else if (key_enter) begin
                    if (cnt_q == CNT_W'(DIGITS)) begin
                        state_d = StSend;
                    end else begin
                        entry_error_d = 1'b1;
                        code_d        = '0;
                        cnt_d         = '0;
                    end
                end else if (key_valid && (cnt_q < CNT_W'(DIGITS))) begin
                    code_d = {code_q[CODE_W-DIGIT_W-1:0], key_digit};
                    cnt_d  = cnt_q + 1'b1;
                end
            end
            StSend: begin
                // Lock responses during the strobe cycle are deliberately not looked at.
                timer_d = '0;
                state_d = StWaitResp;
            end
            StWaitResp: begin
                if (lock_locked) begin
                    state_d = StLockout;
                end else if (lock_ok) begin
                    state_d = StGranted;
                    fail_d  = 2'd0;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(RESP_TIMEOUT - 1)) begin
                    state_d  = StCollect;
                    denied_d = 1'b1;
                    fail_d   = (fail_q == 2'd3) ? 2'd3 : fail_q + 2'd1;
                    code_d   = '0;
                    cnt_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StGranted: begin
                if (timer_q == TMR_W'(GRANT_HOLD - 1)) begin
                    state_d = StCollect;
                    code_d  = '0;
                    cnt_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            StLockout: state_d = StLockout;
            default:   state_d = StCollect;
        endcase
    end

    // Level outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StCollect;
            code_q        <= '0;
            cnt_q         <= '0;
            fail_q        <= 2'd0;
            timer_q       <= '0;
            code_valid_q  <= 1'b0;
            granted_q     <= 1'b0;
            denied_q      <= 1'b0;
            entry_error_q <= 1'b0;
            locked_out_q  <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            code_q        <= code_d;
            cnt_q         <= cnt_d;
            fail_q        <= fail_d;
            timer_q       <= timer_d;
            code_valid_q  <= (state_d == StSend);
            granted_q     <= (state_d == StGranted);
            denied_q      <= denied_d;
            entry_error_q <= entry_error_d;
            locked_out_q  <= (state_d == StLockout);
            busy_q        <= (state_d != StCollect);
        end
    end

    assign code        = code_q;
    assign code_valid  = code_valid_q;
    assign granted     = granted_q;
    assign denied      = denied_q;
    assign entry_error = entry_error_q;
    assign locked_out  = locked_out_q;
    assign digit_count = cnt_q;
    assign fail_count  = fail_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_keypad_code_entry.sv
// Self-checking bench for keypad_code_entry: randomized digits and response delays checked
// against timing and code values derived directly from the lock protocol rules.
module tb_keypad_code_entry;

    localparam int DIGITS       = 4;
    localparam int DIGIT_W      = 4;
    localparam int RESP_TIMEOUT = 8;
    localparam int GRANT_HOLD   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        key_valid, key_clear, key_enter, lock_ok, lock_locked;
    logic [3:0]  key_digit;
    logic [15:0] code;
    logic        code_valid, granted, denied, entry_error, locked_out, busy;
    logic [2:0]  digit_count;
    logic [1:0]  fail_count;

    int checks   = 0;
    int failures = 0;

    keypad_code_entry #(
        .DIGITS      (DIGITS),
        .DIGIT_W     (DIGIT_W),
        .RESP_TIMEOUT(RESP_TIMEOUT),
        .GRANT_HOLD  (GRANT_HOLD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .key_valid  (key_valid),
        .key_digit  (key_digit),
        .key_clear  (key_clear),
        .key_enter  (key_enter),
        .lock_ok    (lock_ok),
        .lock_locked(lock_locked),
        .code       (code),
        .code_valid (code_valid),
        .granted    (granted),
        .denied     (denied),
        .entry_error(entry_error),
        .locked_out (locked_out),
        .digit_count(digit_count),
        .fail_count (fail_count),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the code is the first DIGITS keyed digits, first digit most significant.
    function automatic logic [15:0] model_code(input int q[$]);
        int c = 0;
        for (int i = 0; i < q.size() && i < DIGITS; i++) c = c * 16 + q[i];
        return 16'(c);
    endfunction

    task automatic press(input int d);
        key_valid = 1'b1;
        key_digit = 4'(d);
        tick();
        key_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Keys four random digits and presses enter; returns in the cycle after enter.
    task automatic enter_code(output logic [15:0] exp);
        int q[$];
        for (int i = 0; i < DIGITS; i++) begin
            q.push_back($urandom_range(0, 15));
            press(q[i]);
        end
        exp = model_code(q);
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if ({code_valid, granted, denied, entry_error, locked_out, busy} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b want 000000",
                     {code_valid, granted, denied, entry_error, locked_out, busy});
        end
        checks++;
        if ({code, digit_count, fail_count} !== 21'd0) begin
            failures++;
            $display("FAIL reset_regs: code=%h cnt=%0d fail=%0d want all 0",
                     code, digit_count, fail_count);
        end
    endtask

    task automatic test_digit_entry();
        int q[$] = '{1, 2, 3, 4};
        for (int i = 0; i < DIGITS; i++) begin
            press(q[i]);
            checks++;
            if (digit_count !== 3'(i + 1)) begin
                failures++;
                $display("FAIL entry_count: got %0d want %0d", digit_count, i + 1);
            end
        end
        checks++;
        if (code_valid !== 1'b0) begin
            failures++;
            $display("FAIL early_valid: got %b want 0", code_valid);
        end
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        checks++;
        if ({code_valid, busy, code} !== {2'b11, model_code(q)}) begin
            failures++;
            $display("FAIL send: valid=%b busy=%b code=%h want 1 1 %h",
                     code_valid, busy, code, model_code(q));
        end
        tick();
        checks++;
        if ({code_valid, busy, code} !== {2'b01, 16'h1234}) begin
            failures++;
            $display("FAIL send_after: valid=%b busy=%b code=%h want 0 1 1234",
                     code_valid, busy, code);
        end
        do_reset();
    endtask

    task automatic test_timeout();
        logic [15:0] exp;
        int exp_fail = 0;
        for (int r = 0; r < 4; r++) begin
            enter_code(exp);
            exp_fail = (exp_fail < 3) ? exp_fail + 1 : 3;
            for (int k = 1; k <= RESP_TIMEOUT + 2; k++) begin
                tick();
                checks++;
                if (denied !== (k == RESP_TIMEOUT + 1)) begin
                    failures++;
                    $display("FAIL denied_timing: rep %0d cycle %0d got %b", r, k, denied);
                end
            end
            checks++;
            if ({fail_count, digit_count, busy} !== {2'(exp_fail), 3'd0, 1'b0}) begin
                failures++;
                $display("FAIL fail_count: rep %0d fail=%0d cnt=%0d busy=%b want %0d 0 0",
                         r, fail_count, digit_count, busy, exp_fail);
            end
        end
    endtask

    // Grants with lock_ok in WAIT_RESP cycle d; counts the grant window length.
    task automatic run_grant(input int d, input bool_ok_in_send);
        logic [15:0] exp;
        int gcnt = 0;
        enter_code(exp);
        lock_ok = 1'(bool_ok_in_send);
        for (int k = 1; k <= d; k++) begin
            tick();
            lock_ok = 1'b0;
        end
        checks++;
        if (granted !== 1'b0 || denied !== 1'b0) begin
            failures++;
            $display("FAIL pre_grant: granted=%b denied=%b want 0 0", granted, denied);
        end
        lock_ok = 1'b1;
        tick();
        lock_ok = 1'b0;
        for (int i = 0; i < 40 && granted; i++) begin
            gcnt++;
            tick();
        end
        checks++;
        if (gcnt !== GRANT_HOLD) begin
            failures++;
            $display("FAIL grant_len: got %0d want %0d (d=%0d)", gcnt, GRANT_HOLD, d);
        end
        checks++;
        if ({digit_count, fail_count, busy, code} !== 22'd0) begin
            failures++;
            $display("FAIL after_grant: cnt=%0d fail=%0d busy=%b code=%h want all 0",
                     digit_count, fail_count, busy, code);
        end
    endtask

    task automatic test_grant();
        run_grant(2, 0);
        run_grant($urandom_range(1, RESP_TIMEOUT), 0);
    endtask

    task automatic test_response_window();
        run_grant(RESP_TIMEOUT, 1);
    endtask

    task automatic test_entry_edge();
        press($urandom_range(0, 15));
        press($urandom_range(0, 15));
        key_enter = 1'b1;
        tick();
        key_enter = 1'b0;
        checks++;
        if ({entry_error, digit_count, code_valid} !== {1'b1, 3'd0, 1'b0}) begin
            failures++;
            $display("FAIL entry_error: err=%b cnt=%0d valid=%b want 1 0 0",
                     entry_error, digit_count, code_valid);
        end
        tick();
        checks++;
        if (entry_error !== 1'b0) begin
            failures++;
            $display("FAIL entry_error_len: got %b want 0", entry_error);
        end
        begin
            int q[$];
            for (int i = 0; i < DIGITS + 1; i++) begin
                q.push_back($urandom_range(0, 15));
                press(q[i]);
            end
            checks++;
            if ({code, digit_count, entry_error} !== {model_code(q), 3'd4, 1'b0}) begin
                failures++;
                $display("FAIL fifth_digit: code=%h cnt=%0d err=%b want %h 4 0",
                         code, digit_count, entry_error, model_code(q));
            end
        end
        key_clear = 1'b1;
        key_valid = 1'b1;
        tick();
        key_clear = 1'b0;
        key_valid = 1'b0;
        checks++;
        if ({code, digit_count} !== 19'd0) begin
            failures++;
            $display("FAIL clear_valid: code=%h cnt=%0d want 0 0", code, digit_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] exp;
        enter_code(exp);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({code_valid, granted, denied, entry_error, locked_out, busy, code, digit_count}
                !== 25'd0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b code=%h cnt=%0d want all 0",
                     busy, code, digit_count);
        end
        lock_ok = 1'b1;
        tick();
        lock_ok = 1'b0;
        tick();
        checks++;
        if ({granted, busy} !== 2'b00) begin
            failures++;
            $display("FAIL late_ok: granted=%b busy=%b want 0 0", granted, busy);
        end
    endtask

    task automatic test_lockout();
        logic [15:0] exp;
        enter_code(exp);
        tick();
        lock_ok     = 1'b1;
        lock_locked = 1'b1;
        tick();
        lock_ok     = 1'b0;
        lock_locked = 1'b0;
        checks++;
        if ({locked_out, granted, busy} !== 3'b101) begin
            failures++;
            $display("FAIL lockout: locked=%b granted=%b busy=%b want 1 0 1",
                     locked_out, granted, busy);
        end
        key_clear = 1'b1;
        tick();
        key_clear = 1'b0;
        press($urandom_range(0, 15));
        key_enter = 1'b1;
        lock_ok   = 1'b1;
        tick();
        key_enter = 1'b0;
        lock_ok   = 1'b0;
        repeat (RESP_TIMEOUT + GRANT_HOLD) tick();
        checks++;
        if ({code, digit_count, locked_out, granted, denied, code_valid}
                !== {exp, 3'd4, 4'b1000}) begin
            failures++;
            $display("FAIL lockout_keys: code=%h cnt=%0d locked=%b granted=%b want %h 4 1 0",
                     code, digit_count, locked_out, granted, exp);
        end
        do_reset();
        checks++;
        if ({code_valid, granted, denied, entry_error, locked_out, busy, code, digit_count,
             fail_count} !== 27'd0) begin
            failures++;
            $display("FAIL lockout_reset: locked=%b busy=%b code=%h want all 0",
                     locked_out, busy, code);
        end
    endtask

    initial begin
        reset       = 1'b1;
        key_valid   = 1'b0;
        key_digit   = 4'd0;
        key_clear   = 1'b0;
        key_enter   = 1'b0;
        lock_ok     = 1'b0;
        lock_locked = 1'b0;
        test_reset();
        test_digit_entry();
        test_timeout();
        test_grant();
        test_response_window();
        test_entry_edge();
        test_reset_mid();
        test_lockout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/keypad_code_entry.md
Name:
keypad_code_entry

Overview:
- Initiator side of the combination-lock interface: collects keypad digit presses, assembles a multi-digit code and presents it to the lock with a one-cycle valid strobe.
- Interprets the lock's grant/lockout response, with timeout, grant hold and saturating failure count.
- Sits between the keypad scanner/debouncer and the lock checker; drives the user-facing status outputs.

Parameters:
- DIGITS, 4, number of digits per code.
- DIGIT_W, 4, bits per digit.
- RESP_TIMEOUT, 8, cycles the block waits for a lock response after code_valid.
- GRANT_HOLD, 16, cycles granted stays high after a successful response.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- key_valid  in  1  one-cycle strobe: key_digit holds a new digit.
- key_digit  in  DIGIT_W  digit value, sampled when key_valid=1.
- key_clear  in  1  one-cycle strobe: discard the partial entry.
- key_enter  in  1  one-cycle strobe: submit the entry.
- lock_ok  in  1  lock response: code accepted.
- lock_locked  in  1  lock response: lock has entered lockout.
- code  out  DIGITS*DIGIT_W  assembled code; first digit in the MSBs.
- code_valid  out  1  one-cycle strobe: code is valid for the lock.
- granted  out  1  access granted, held GRANT_HOLD cycles.
- denied  out  1  one-cycle pulse: no response before timeout.
- entry_error  out  1  one-cycle pulse: enter pressed with an incomplete entry.
- locked_out  out  1  sticky lockout indication, cleared only by reset.
- digit_count  out  clog2(DIGITS+1)  digits currently collected.
- fail_count  out  2  denied attempts, saturates at 3.
- busy  out  1  high in SEND, WAIT_RESP, GRANTED and LOCKOUT.

Behaviour:
- Reset: state=COLLECT; code, digit_count and fail_count = 0; code_valid, granted, denied, entry_error, locked_out and busy = 0.
- Clock and reset: single clock clk; reset is synchronous and active-high. Reset has priority over every other input and aborts any state, including mid-wait and mid-grant.
- States: COLLECT, SEND, WAIT_RESP, GRANTED, LOCKOUT.
- COLLECT, per-cycle priority: key_clear, then key_enter, then key_valid.
  - key_clear: code=0, digit_count=0.
  - key_enter with digit_count==DIGITS: go to SEND; the code register is frozen.
  - key_enter with digit_count<DIGITS: entry_error=1 next cycle for one cycle; code=0, digit_count=0; stay in COLLECT.
  - key_valid with digit_count<DIGITS: code <= {code[DIGITS*DIGIT_W-DIGIT_W-1:0], key_digit}; digit_count+1.
  - key_valid with digit_count==DIGITS: ignored, with no error.
- SEND (one cycle): code_valid=1 and code is stable; next state WAIT_RESP. The response counter is cleared.
- WAIT_RESP:
  - lock_locked and lock_ok are sampled every cycle; lock_locked wins if both are high.
  - lock_locked=1: go to LOCKOUT; locked_out=1 from the next cycle.
  - lock_ok=1: go to GRANTED; granted=1 from the next cycle; fail_count=0.
  - Neither response within RESP_TIMEOUT cycles after the SEND cycle: denied=1 for one cycle; fail_count+1, saturating at 3; code and digit_count cleared; return to COLLECT.
  - Responses that arrive in the SEND cycle itself are ignored.
- GRANTED: granted held for exactly GRANT_HOLD cycles, then deasserted; code and digit_count cleared; return to COLLECT. Lock inputs are ignored.
- LOCKOUT: terminal until reset. locked_out=1 and busy=1; all key and lock inputs are ignored.
- Keys while busy: key_valid, key_clear and key_enter are ignored in every state except COLLECT.
- Registered outputs: all outputs are registered. code_valid, denied and entry_error are never high for more than one cycle.

Test Plan:
- Digit entry: key digits 1,2,3,4, then key_enter → code=16'h1234; code_valid high for exactly 1 cycle, 1 cycle after enter; busy=1.
- Grant: after submitting 1234, drive lock_ok for 1 cycle, 2 cycles after code_valid → granted high for exactly 16 cycles, then COLLECT with digit_count=0; fail_count reset to 0.
- Timeout and saturation: submit 1234 with no response → denied pulses on cycle 9 after code_valid. Repeat 4 times → fail_count reads 1,2,3,3.
- Lockout: lock_locked and lock_ok both high 1 cycle after code_valid → locked_out=1 and granted=0. Subsequent keys have no effect on code or digit_count. reset → all outputs 0.
- Entry edge cases:
  - Digits 5,6, then key_enter → entry_error 1-cycle pulse, digit_count=0.
  - Digits 1..5 → code=16'h1234 (fifth digit ignored).
  - key_clear and key_valid in the same cycle → digit_count=0.
- Reset mid-operation: reset asserted in WAIT_RESP cycle 3 → next cycle state COLLECT, all outputs 0. A lock_ok arriving afterwards does not set granted.
